logic_unit_arbiter: RTL and testbench

//  Shares one WIDTH-bit bitwise logic unit (XOR/AND/OR/XNOR) between two requesters.

---
 rtl/logic_unit_arbiter.sv | 115 +++++++++++
 tb/tb_logic_unit_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin front end for a shared bitwise logic unit.
// One registered result slot with valid/ready backpressure.
module logic_unit_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req1_op,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_y,
   output logic             res_id
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   localparam logic [1:0] OP_XOR  = 2'b00;
   localparam logic [1:0] OP_AND  = 2'b01;
   localparam logic [1:0] OP_OR   = 2'b10;
   localparam logic [1:0] OP_XNOR = 2'b11;

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             id_q, id_d;

   logic             slot_free;
   logic             grant0, grant1;
   logic             accept;
   logic [WIDTH-1:0] sel_a, sel_b;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] lu_y;

   // Ties between two valid requesters go to the side named by prio_q.
   assign grant0 = req0_valid & (~req1_valid | ~prio_q);
   assign grant1 = req1_valid & (~req0_valid |  prio_q);

   assign slot_free  = (state_q == EMPTY) | res_ready;
   assign req0_ready = slot_free & grant0 & ~rst;
   assign req1_ready = slot_free & grant1 & ~rst;
   assign accept     = req0_ready | req1_ready;

   always_comb begin
      sel_a  = req0_a;
      sel_b  = req0_b;
      sel_op = req0_op;
      if (req1_ready) begin
         sel_a  = req1_a;
         sel_b  = req1_b;
         sel_op = req1_op;
      end
   end

   always_comb begin
      lu_y = '0;
      unique case (sel_op)
         OP_XOR:  lu_y = sel_a ^ sel_b;
         OP_AND:  lu_y = sel_a & sel_b;
         OP_OR:   lu_y = sel_a | sel_b;
         OP_XNOR: lu_y = ~(sel_a ^ sel_b);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         prio_q  <= 1'b0;
         y_q     <= '0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         y_q     <= y_d;
         id_q    <= id_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL:  if (res_ready && !accept) state_d = EMPTY;
      endcase
   end

   always_comb begin
      prio_d = prio_q;
      y_d    = y_q;
      id_d   = id_q;
      if (accept) begin
         prio_d = ~req1_ready;
         y_d    = lu_y;
         id_d   = req1_ready;
      end
   end

   always_comb begin
      res_valid = (state_q == FULL);
      res_y     = y_q;
      res_id    = id_q;
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_logic_unit_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic [1:0]  req0_op;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic [1:0]  req1_op;
   logic        res_valid, res_ready;
   logic [31:0] res_y;
   logic        res_id;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   logic_unit_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_y(res_y), .res_id(res_id)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = 32'h0000_00FF; req0_b = 32'h0; req0_op = 2'b10;
      req1_valid = 1'b1; req1_a = 32'h0000_FF00; req1_b = 32'h0; req1_op = 2'b10;
      res_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%b want=0", res_valid);
      end
      checks++;
      if (res_y !== 32'h0) begin
         failures++; $display("FAIL reset_y got=%h want=0", res_y);
      end
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_first_grant got=%b%b want=10", req0_ready, req1_ready);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_id !== 1'b0 || res_y !== 32'h0000_00FF) begin
         failures++;
         $display("FAIL reset_first_result got v=%b id=%b y=%h want v=1 id=0 y=000000ff",
                  res_valid, res_id, res_y);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
         failures++; $display("FAIL reset_drain got=%b want=0", res_valid);
      end
   endtask

   task automatic test_single_op;
      logic [31:0] exp [4];
      exp[0] = 32'hF0F0_0F0F;
      exp[1] = 32'h0F0F_0000;
      exp[2] = 32'hFFFF_0F0F;
      exp[3] = 32'h0F0F_F0F0;
      req0_valid = 1'b1;
      req0_a = 32'hFFFF_0000;
      req0_b = 32'h0F0F_0F0F;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req0_op = 2'(i);
         tick();
         checks++;
         if (res_valid !== 1'b1 || res_id !== 1'b0 || res_y !== exp[i]) begin
            failures++;
            $display("FAIL single_op%0d got v=%b id=%b y=%h want v=1 id=0 y=%h",
                     i, res_valid, res_id, res_y, exp[i]);
         end
      end
      req0_valid = 1'b0;
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
         failures++; $display("FAIL single_drain got=%b want=0", res_valid);
      end
   endtask

   task automatic test_contention;
      logic [31:0] exp_y;
      logic        exp_id;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'hFFFF_FFFF; req0_op = 2'b00;
      req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_b = 32'h0F0F_0F0F; req1_op = 2'b01;
      res_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_id = 1'(i % 2);
         exp_y  = exp_id ? 32'h0204_0608 : 32'hEDCB_A987;
         tick();
         checks++;
         if (res_valid !== 1'b1 || res_id !== exp_id || res_y !== exp_y) begin
            failures++;
            $display("FAIL contention%0d got v=%b id=%b y=%h want v=1 id=%b y=%h",
                     i, res_valid, res_id, res_y, exp_id, exp_y);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_backpressure;
      req0_valid = 1'b1; req0_a = 32'h00FF_00FF; req0_b = 32'h0F00_0000; req0_op = 2'b10;
      res_ready = 1'b1;
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_id !== 1'b0 || res_y !== 32'h0FFF_00FF) begin
         failures++;
         $display("FAIL bp_load got v=%b id=%b y=%h want v=1 id=0 y=0fff00ff",
                  res_valid, res_id, res_y);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b1; req1_a = 32'hAAAA_5555; req1_b = 32'hFFFF_0000; req1_op = 2'b00;
      res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (req1_ready !== 1'b0) begin
            failures++; $display("FAIL bp_ready%0d got=%b want=0", i, req1_ready);
         end
         tick();
         checks++;
         if (res_valid !== 1'b1 || res_id !== 1'b0 || res_y !== 32'h0FFF_00FF) begin
            failures++;
            $display("FAIL bp_hold%0d got v=%b id=%b y=%h want v=1 id=0 y=0fff00ff",
                     i, res_valid, res_id, res_y);
         end
      end
      res_ready = 1'b1;
      #1;
      checks++;
      if (req1_ready !== 1'b1) begin
         failures++; $display("FAIL bp_release_ready got=%b want=1", req1_ready);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_id !== 1'b1 || res_y !== 32'h5555_5555) begin
         failures++;
         $display("FAIL bp_release got v=%b id=%b y=%h want v=1 id=1 y=55555555",
                  res_valid, res_id, res_y);
      end
      req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid;
      req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1234_5678; req0_op = 2'b01;
      res_ready = 1'b0;
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_y !== 32'h1234_5678) begin
         failures++;
         $display("FAIL mid_load got v=%b y=%h want v=1 y=12345678", res_valid, res_y);
      end
      req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF; req1_op = 2'b00;
      rst = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst_ready got=%b%b want=00", req0_ready, req1_ready);
      end
      tick();
      checks++;
      if (res_valid !== 1'b0 || res_y !== 32'h0 || res_id !== 1'b0) begin
         failures++;
         $display("FAIL mid_rst got v=%b id=%b y=%h want v=0 id=0 y=0",
                  res_valid, res_id, res_y);
      end
      rst = 1'b0;
      req0_b = 32'h0000_FFFF;
      res_ready = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_prio got=%b%b want=10", req0_ready, req1_ready);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_id !== 1'b0 || res_y !== 32'h0000_FFFF) begin
         failures++;
         $display("FAIL mid_after got v=%b id=%b y=%h want v=1 id=0 y=0000ffff",
                  res_valid, res_id, res_y);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_operand_stability;
      req0_valid = 1'b1; req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_op = 2'b11;
      res_ready = 1'b0;
      tick();
      req0_a = 32'h0000_0000;
      req0_valid = 1'b0;
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_y !== 32'hF00F_F00F) begin
         failures++;
         $display("FAIL stab_hold got v=%b y=%h want v=1 y=f00ff00f", res_valid, res_y);
      end
      req0_valid = 1'b1;
      tick();
      checks++;
      if (res_y !== 32'hF00F_F00F || res_id !== 1'b0) begin
         failures++;
         $display("FAIL stab_blocked got id=%b y=%h want id=0 y=f00ff00f", res_id, res_y);
      end
      req0_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
         failures++; $display("FAIL stab_drain got=%b want=0", res_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
      res_ready = 1'b0;
      test_reset();
      test_single_op();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_operand_stability();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
